// File: rtl/fpu_mul_pkg.sv
// Shared widths, FSM encoding and exponent limits for the FP32 multiplier
// mantissa/normalization datapath.
package fpu_mul_pkg;
  localparam int MW           = 24;
  localparam int PW           = 48;
  localparam int EW           = 10;
  localparam int EXP_MIN_NORM = 1;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    NORM,
    DONE
  } state_t;
endpackage

// File: rtl/mant_shift_add_core.sv
// Iterative radix-2^RADIX_BITS shift-add multiplier: accumulator, multiplier
// shift register and iteration counter.
module mant_shift_add_core #(
  parameter int RADIX_BITS = 2,
  parameter int MW         = 24,
  parameter int PW         = 2 * MW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          load,
  input  logic          step,
  input  logic [MW-1:0] mcand,
  input  logic [MW-1:0] mplier,
  output logic          last,
  output logic [PW-1:0] acc_sum
);
  localparam int STEPS = MW / RADIX_BITS;
  localparam int CW    = $clog2(STEPS);

  logic [PW-1:0] acc_reg;
  logic [PW-1:0] mcand_reg;
  logic [MW-1:0] mplier_reg;
  logic [CW-1:0] cnt_reg;
  logic [PW-1:0] pp [RADIX_BITS];
  logic [PW-1:0] partial;

  // The multiplicand is pre-shifted by RADIX_BITS each step, so the digit
  // weight never needs a variable shifter.
  generate
    for (genvar gi = 0; gi < RADIX_BITS; gi++) begin : g_pp
      assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
    end
  endgenerate

  always_comb begin
    partial = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      partial = partial + pp[i];
    end
  end

  assign acc_sum = acc_reg + partial;
  assign last    = (cnt_reg == CW'(STEPS - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
    end else if (load) begin
      acc_reg    <= '0;
      mcand_reg  <= PW'(mcand);
      mplier_reg <= mplier;
      cnt_reg    <= '0;
    end else if (step) begin
      acc_reg    <= acc_sum;
      mcand_reg  <= mcand_reg << RADIX_BITS;
      mplier_reg <= mplier_reg >> RADIX_BITS;
      cnt_reg    <= last ? '0 : cnt_reg + 1'b1;
    end
  end
endmodule

// File: rtl/mantissa_multiply_normalize.sv
// Mantissa product and leading-one normalization for the FP32 multiplier;
// the first post-multiply cycle evaluates zero / already-normalized / shift.
module mantissa_multiply_normalize #(
  parameter int RADIX_BITS = 2,
  parameter int MW         = fpu_mul_pkg::MW,
  parameter int EW         = fpu_mul_pkg::EW
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic            Sx_in,
  input  logic            Sy_in,
  input  logic [MW-1:0]   Mx_conc,
  input  logic [MW-1:0]   My_conc,
  input  logic [EW-1:0]   Ez_add,
  output logic            ready,
  output logic            done,
  output logic            Sz,
  output logic [2*MW-1:0] Mz_norm,
  output logic [EW-1:0]   Ez_norm,
  output logic            zero
);
  import fpu_mul_pkg::state_t, fpu_mul_pkg::IDLE, fpu_mul_pkg::MULT,
         fpu_mul_pkg::NORM, fpu_mul_pkg::DONE, fpu_mul_pkg::EXP_MIN_NORM;

  localparam int PW = 2 * MW;

  state_t          state_reg, state_next;
  logic [PW-1:0]   p_reg, p_next;
  logic [EW-1:0]   exp_reg, exp_next;
  logic            sign_reg, sign_next;
  logic            sz_reg, sz_next;
  logic [PW-1:0]   mz_reg, mz_next;
  logic [EW-1:0]   ez_reg, ez_next;
  logic            zero_reg, zero_next;
  logic            core_load, core_step, core_last;
  logic [PW-1:0]   acc_sum;
  logic            can_shift;

  mant_shift_add_core #(
    .RADIX_BITS(RADIX_BITS),
    .MW        (MW),
    .PW        (PW)
  ) u_core (
    .CLK    (CLK),
    .RST    (RST),
    .load   (core_load),
    .step   (core_step),
    .mcand  (Mx_conc),
    .mplier (My_conc),
    .last   (core_last),
    .acc_sum(acc_sum)
  );

  // Shifting stops at the smallest normal exponent; rounding takes the subnormal.
  assign can_shift = !p_reg[PW-1] && ($signed(exp_reg) > $signed(EW'(EXP_MIN_NORM)));

  always_comb begin
    state_next = state_reg;
    p_next     = p_reg;
    exp_next   = exp_reg;
    sign_next  = sign_reg;
    sz_next    = sz_reg;
    mz_next    = mz_reg;
    ez_next    = ez_reg;
    zero_next  = zero_reg;
    core_load  = 1'b0;
    core_step  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          core_load  = 1'b1;
          sign_next  = Sx_in ^ Sy_in;
          exp_next   = Ez_add;
          state_next = MULT;
        end
      end
      MULT: begin
        core_step = 1'b1;
        if (core_last) begin
          p_next     = acc_sum;
          exp_next   = exp_reg + EW'(1);
          state_next = NORM;
        end
      end
      NORM: begin
        if (p_reg == '0) begin
          sz_next    = sign_reg;
          mz_next    = '0;
          ez_next    = '0;
          zero_next  = 1'b1;
          state_next = DONE;
        end else if (can_shift) begin
          p_next   = p_reg << 1;
          exp_next = exp_reg - EW'(1);
        end else begin
          sz_next    = sign_reg;
          mz_next    = p_reg;
          ez_next    = exp_reg;
          zero_next  = 1'b0;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= IDLE;
      p_reg     <= '0;
      exp_reg   <= '0;
      sign_reg  <= 1'b0;
      sz_reg    <= 1'b0;
      mz_reg    <= '0;
      ez_reg    <= '0;
      zero_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      p_reg     <= p_next;
      exp_reg   <= exp_next;
      sign_reg  <= sign_next;
      sz_reg    <= sz_next;
      mz_reg    <= mz_next;
      ez_reg    <= ez_next;
      zero_reg  <= zero_next;
    end
  end

  assign ready   = (state_reg == IDLE);
  assign done    = (state_reg == DONE);
  assign Sz      = sz_reg;
  assign Mz_norm = mz_reg;
  assign Ez_norm = ez_reg;
  assign zero    = zero_reg;
endmodule

// File: tb/tb_mantissa_multiply_normalize.sv
// Table-driven plus randomized scoreboard bench for mantissa_multiply_normalize.
module tb_mantissa_multiply_normalize;
  typedef struct {
    logic        sx;
    logic        sy;
    logic [23:0] mx;
    logic [23:0] my;
    logic [9:0]  ez;
    logic        esz;
    logic [47:0] emz;
    logic [9:0]  eez;
    logic        ezero;
    int          elat;
  } vec_t;

  typedef struct {
    logic        sz;
    logic [47:0] mz;
    logic [9:0]  ez;
    logic        zero;
    int          lat;
    int          acc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic        Sx_in = 1'b0;
  logic        Sy_in = 1'b0;
  logic [23:0] Mx_conc = '0;
  logic [23:0] My_conc = '0;
  logic [9:0]  Ez_add = '0;
  logic        ready, done, Sz, zero;
  logic [47:0] Mz_norm;
  logic [9:0]  Ez_norm;

  mantissa_multiply_normalize dut (
    .CLK    (CLK),
    .RST    (RST),
    .start  (start),
    .Sx_in  (Sx_in),
    .Sy_in  (Sy_in),
    .Mx_conc(Mx_conc),
    .My_conc(My_conc),
    .Ez_add (Ez_add),
    .ready  (ready),
    .done   (done),
    .Sz     (Sz),
    .Mz_norm(Mz_norm),
    .Ez_norm(Ez_norm),
    .zero   (zero)
  );

  always #5 CLK = ~CLK;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[7];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic vec_t mkvec(input logic sx, input logic sy, input logic [23:0] mx,
                                 input logic [23:0] my, input logic [9:0] ez,
                                 input logic esz, input logic [47:0] emz,
                                 input logic [9:0] eez, input logic ezero, input int elat);
    vec_t v;
    v.sx = sx; v.sy = sy; v.mx = mx; v.my = my; v.ez = ez;
    v.esz = esz; v.emz = emz; v.eez = eez; v.ezero = ezero; v.elat = elat;
    return v;
  endfunction

  // Reference: full product, then left-normalize with the exponent floor at 1.
  function automatic vec_t model(input logic sx, input logic sy, input logic [23:0] mx,
                                 input logic [23:0] my, input logic [9:0] ez);
    vec_t v;
    logic [47:0] p;
    logic signed [9:0] e;
    int sh;
    p = 48'(mx) * 48'(my);
    v.sx = sx; v.sy = sy; v.mx = mx; v.my = my; v.ez = ez;
    v.esz = sx ^ sy;
    if (p == 48'd0) begin
      v.emz = '0; v.eez = '0; v.ezero = 1'b1; v.elat = 13;
    end else begin
      e = $signed(ez) + 10'sd1;
      sh = 0;
      while (!p[47] && e > 10'sd1) begin
        p = p << 1;
        e = e - 10'sd1;
        sh++;
      end
      v.emz = p; v.eez = e; v.ezero = 1'b0; v.elat = 13 + sh;
    end
    return v;
  endfunction

  function automatic exp_t to_exp(input vec_t v, input int acc);
    exp_t e;
    e.sz = v.esz; e.mz = v.emz; e.ez = v.eez; e.zero = v.ezero; e.lat = v.elat; e.acc = acc;
    return e;
  endfunction

  always @(negedge CLK) begin
    if (RST && done) begin
      if (sb.size() == 0) begin
        fail_now("done_without_request");
      end else begin
        mon_e = sb.pop_front();
        $display("txn done: Sz=%0b Mz_norm=%012h Ez_norm=%0d zero=%0b latency=%0d",
                 Sz, Mz_norm, $signed(Ez_norm), zero, cyc - mon_e.acc);
        check("Sz", 64'(Sz), 64'(mon_e.sz));
        check("Mz_norm", 64'(Mz_norm), 64'(mon_e.mz));
        check("Ez_norm", 64'(Ez_norm), 64'(mon_e.ez));
        check("zero", 64'(zero), 64'(mon_e.zero));
        check("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
        check("ready_in_done", 64'(ready), 64'd0);
      end
    end
  end

  task automatic wait_ready();
    int w;
    w = 0;
    @(negedge CLK);
    while (!ready && w < 100) begin
      @(negedge CLK);
      w++;
    end
    if (!ready) fail_now("ready_timeout");
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge CLK);
      w++;
    end
    if (sb.size() != 0) begin
      fail_now("done_timeout");
      sb.delete();
    end
  endtask

  task automatic drive(input vec_t v);
    Sx_in = v.sx; Sy_in = v.sy; Mx_conc = v.mx; My_conc = v.my; Ez_add = v.ez;
    start = 1'b1;
    sb.push_back(to_exp(v, cyc + 1));
  endtask

  task automatic run_op(input vec_t v);
    wait_ready();
    drive(v);
    @(posedge CLK);
    #1;
    start = 1'b0;
    Mx_conc = 24'($urandom); My_conc = 24'($urandom); Ez_add = 10'($urandom);
    Sx_in = ~Sx_in;
    @(negedge CLK);
    check("ready_low_after_accept", 64'(ready), 64'd0);
    wait_drain();
  endtask

  initial begin
    vec_t v, va, vb;
    int w;

    tbl[0] = mkvec(0, 0, 24'h800000, 24'h800000, 10'd127, 0, 48'h800000000000, 10'd127, 0, 14);
    tbl[1] = mkvec(0, 0, 24'hC00000, 24'hC00000, 10'd127, 0, 48'h900000000000, 10'd128, 0, 13);
    tbl[2] = mkvec(1, 0, 24'hFFFFFF, 24'hFFFFFF, 10'd254, 1, 48'hFFFFFE000001, 10'd255, 0, 13);
    tbl[3] = mkvec(0, 0, 24'h000000, 24'hABCDEF, 10'd127, 0, 48'h000000000000, 10'd0, 1, 13);
    tbl[4] = mkvec(0, 0, 24'h000001, 24'h800000, 10'd1, 0, 48'h000001000000, 10'd1, 0, 14);
    tbl[5] = mkvec(1, 1, 24'h000001, 24'h800000, 10'h3FB, 0, 48'h000000800000, 10'h3FC, 0, 13);
    tbl[6] = mkvec(0, 1, 24'h800000, 24'h000001, 10'd200, 1, 48'h800000000000, 10'd177, 0, 37);

    RST = 1'b0;
    #1;
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_done", 64'(done), 64'd0);
    check("reset_Mz", 64'(Mz_norm), 64'd0);
    check("reset_Ez", 64'(Ez_norm), 64'd0);
    check("reset_Sz", 64'(Sz), 64'd0);
    check("reset_zero", 64'(zero), 64'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 7; i++) run_op(tbl[i]);

    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0)
        v = model(1'($urandom), 1'($urandom), 24'($urandom_range(0, 4095)),
                  {1'b1, 23'($urandom)}, 10'($urandom));
      else
        v = model(1'($urandom), 1'($urandom), {1'b1, 23'($urandom)},
                  {1'b1, 23'($urandom)}, 10'($urandom));
      run_op(v);
    end

    // start held high: the second operand set may only be taken in the next IDLE.
    va = tbl[2];
    vb = tbl[0];
    wait_ready();
    drive(va);
    @(posedge CLK);
    #1;
    Sx_in = vb.sx; Sy_in = vb.sy; Mx_conc = vb.mx; My_conc = vb.my; Ez_add = vb.ez;
    w = 0;
    do begin
      @(negedge CLK);
      w++;
    end while (!done && w < 100);
    if (!done) begin
      fail_now("hold_done_timeout");
    end else begin
      sb.push_back(to_exp(vb, cyc + 2));
      @(negedge CLK);
      check("ready_after_done", 64'(ready), 64'd1);
      @(posedge CLK);
      #1;
      start = 1'b0;
    end
    wait_drain();

    // Reset in MULT cycle 5 aborts with no done pulse.
    wait_ready();
    drive(tbl[2]);
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    sb.delete();
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_done", 64'(done), 64'd0);
    check("abort_Mz", 64'(Mz_norm), 64'd0);
    check("abort_Ez", 64'(Ez_norm), 64'd0);
    check("abort_Sz", 64'(Sz), 64'd0);
    check("abort_zero", 64'(zero), 64'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (20) @(negedge CLK);
    run_op(tbl[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
